// File: rtl/math_sequencer.sv
// rtl/math_sequencer.sv - ADD/SUB/MUL/DIV sequencer around one shared add/subtract datapath
// MUL is shift-add LSB first on {hi,lo}; DIV is restoring MSB first with hi=remainder, lo=quotient.
module math_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               err
);
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [SW-1:0]      step_q, step_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               err_q, err_d;

    // Shared adder/subtractor, two guard bits so a DIV trial subtract shows its sign in the MSB
    logic [WIDTH+1:0] alu_x, alu_y, alu_s;
    logic             alu_sub;

    always_comb begin
        alu_x   = '0;
        alu_y   = {2'b00, b_q};
        alu_sub = 1'b0;
        case (op_q)
            OP_ADD: alu_x = {2'b00, a_q};
            OP_SUB: begin
                alu_x   = {2'b00, a_q};
                alu_sub = 1'b1;
            end
            OP_MUL: begin
                alu_x = {2'b00, hi_q};
                alu_y = {2'b00, a_q};
            end
            default: begin
                alu_x   = {1'b0, hi_q, lo_q[WIDTH-1]};
                alu_sub = 1'b1;
            end
        endcase
    end

    assign alu_s = alu_x + (alu_sub ? ~alu_y : alu_y) + (WIDTH+2)'(alu_sub);

    logic [WIDTH:0]   mul_new;
    logic             div_neg;
    logic [WIDTH-1:0] rem_n, quot_n;
    logic             last_step;

    assign mul_new   = lo_q[0] ? alu_s[WIDTH:0] : {1'b0, hi_q};
    assign div_neg   = alu_s[WIDTH+1];
    assign rem_n     = div_neg ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : alu_s[WIDTH-1:0];
    assign quot_n    = {lo_q[WIDTH-2:0], ~div_neg};
    assign last_step = (step_q == SW'(WIDTH-1));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        step_d   = step_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EXEC;
                    op_d    = op;
                    a_d     = A;
                    b_d     = B;
                    hi_d    = '0;
                    lo_d    = (op == OP_MUL) ? B : A;
                    step_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        result_d = {{WIDTH{1'b0}}, alu_s[WIDTH-1:0]};
                        state_d  = S_DONE;
                    end
                    OP_MUL: begin
                        hi_d   = mul_new[WIDTH:1];
                        lo_d   = {mul_new[0], lo_q[WIDTH-1:1]};
                        step_d = step_q + 1'b1;
                        if (last_step) begin
                            result_d = {mul_new, lo_q[WIDTH-1:1]};
                            state_d  = S_DONE;
                        end
                    end
                    default: begin
                        if (b_q == '0) begin
                            result_d = '1;
                            err_d    = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            hi_d   = rem_n;
                            lo_d   = quot_n;
                            step_d = step_q + 1'b1;
                            if (last_step) begin
                                result_d = {rem_n, quot_n};
                                state_d  = S_DONE;
                            end
                        end
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            step_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            step_q   <= step_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == S_EXEC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign err    = err_q;
endmodule

// File: tb/tb_math_sequencer.sv
// tb/tb_math_sequencer.sv - scoreboard bench for math_sequencer with directed and random transactions
module tb_math_sequencer;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [1:0] op;
    logic [3:0] A, B;
    logic       busy, done, err;
    logic [7:0] result;

    math_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         acc;
        int         dc;
    } exp_t;
    exp_t sb[$];

    // Accept happens at the edge ending the current cycle
    task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int ia, ib, lat;
        ia = a;
        ib = b;
        e.err = 1'b0;
        lat = 2;
        case (o)
            2'd0: e.res = 8'((ia + ib) % 16);
            2'd1: e.res = 8'((ia - ib + 16) % 16);
            2'd2: begin e.res = 8'(ia * ib); lat = 5; end
            default: begin
                if (ib == 0) begin
                    e.res = 8'hFF;
                    e.err = 1'b1;
                end else begin
                    e.res = 8'((ia % ib) * 16 + ia / ib);
                    lat = 5;
                end
            end
        endcase
        e.acc = cyc;
        e.dc  = cyc + lat;
        sb.push_back(e);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); A = 4'($urandom); B = 4'($urandom);
    endtask

    task automatic wait_idle(input bit noise);
        int k;
        for (k = 0; k < 40; k++) begin
            if (!busy && !done) break;
            if (noise) begin
                start = 1'($urandom);
                op = 2'($urandom); A = 4'($urandom); B = 4'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (k == 40) chk("idle_timeout", 0, 1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic eb;
        if (!reset) begin
            eb = (sb.size() > 0) && (cyc > sb[0].acc) && (cyc < sb[0].dc);
            chk("busy", busy, eb);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.dc);
                    chk("result", result, e.res);
                    chk("err", err, e.err);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].dc) begin
                void'(sb.pop_front());
                chk("missing_done", 0, 1);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; A = 4'd0; B = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 8'h00);
        chk("rst_err", err, 0);

        issue(2'd0, 4'd9, 4'd8);   wait_idle(0);
        issue(2'd1, 4'd3, 4'd5);   wait_idle(0);
        issue(2'd1, 4'd7, 4'd7);   wait_idle(0);
        issue(2'd2, 4'd15, 4'd15); wait_idle(0);
        issue(2'd2, 4'd0, 4'd9);   wait_idle(0);
        issue(2'd3, 4'd13, 4'd4);  wait_idle(0);
        issue(2'd3, 4'd2, 4'd7);   wait_idle(0);
        issue(2'd3, 4'd9, 4'd0);   wait_idle(0);
        issue(2'd0, 4'd1, 4'd1);   wait_idle(0);

        // start pulse during MUL step 2 must be ignored
        issue(2'd2, 4'd15, 4'd15);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; A = 4'd1; B = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(0);

        // reset during DIV step 1 aborts with no done pulse
        issue(2'd3, 4'd13, 4'd4);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 8'h00);
        chk("abort_err", err, 0);
        issue(2'd0, 4'd6, 4'd5);   wait_idle(0);

        for (int i = 0; i < 200; i++) begin
            issue(2'($urandom), 4'($urandom), 4'($urandom));
            wait_idle(1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
